// File: rtl/regfile_writeback_unit_pkg.sv
// Shared writeback constants, source enum and helpers.
// Imported by the writeback unit, its scoreboard and the register file.
package regfile_writeback_unit_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int WB_CNT_WIDTH  = 2;
  localparam int WB_CNT_MAX    = (1 << WB_CNT_WIDTH) - 1;
  localparam int WB_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

  function automatic logic src_writes(
    input wb_src_e src,
    input logic    rd_nonzero
  );
    return (src != SRC_NONE) && rd_nonzero;
  endfunction

endpackage

// File: rtl/regfile_writeback_unit_scoreboard.sv
// Per-register pending-write counters with inc/dec ports, busy
// queries, saturation query, all-zero flag and sticky underflow err.
module wb_scoreboard
  import regfile_writeback_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = WB_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  inc_en,
  input  logic [ADDR_WIDTH-1:0] inc_addr,
  input  logic                  dec_en,
  input  logic [ADDR_WIDTH-1:0] dec_addr,
  input  logic [ADDR_WIDTH-1:0] q_addr,
  output logic                  q_sat,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  all_zero,
  output logic                  err
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [CNT_WIDTH-1:0] cnt [NREG];
  logic [CNT_WIDTH-1:0] cnt_max;
  logic [NREG-1:0]      inc_vec;
  logic [NREG-1:0]      dec_vec;
  logic [NREG-1:0]      zero_vec;
  logic                 underflow;

  assign cnt_max = '1;

  // x0 never tracks anything, so bit 0 is masked off.
  assign inc_vec = inc_en
    ? ((NREG'(1) << inc_addr) & ~NREG'(1))
    : '0;
  assign dec_vec = dec_en
    ? ((NREG'(1) << dec_addr) & ~NREG'(1))
    : '0;

  always_comb begin
    zero_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      zero_vec[r] = (cnt[r] == '0);
    end
  end

  // A retire with a matching issue in the same cycle is a net zero,
  // not an underflow, even if the counter reads 0.
  assign underflow = |(dec_vec & ~inc_vec & zero_vec);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10:   cnt[r] <= cnt[r] + 1'b1;
          2'b01: begin
            if (!zero_vec[r]) begin
              cnt[r] <= cnt[r] - 1'b1;
            end
          end
          default: cnt[r] <= cnt[r];
        endcase
      end
      if (underflow) begin
        err <= 1'b1;
      end
    end
  end

  assign q_sat    = (cnt[q_addr] == cnt_max);
  assign rs1_busy = (rs1 != '0) && !zero_vec[rs1];
  assign rs2_busy = (rs2 != '0) && !zero_vec[rs2];
  assign all_zero = &zero_vec;

endmodule

// File: rtl/regfile_writeback_unit.sv
// RF write-side controller: arbitrates ALU/LSU results onto a registered
// write port, tracks pending writes for decode RAW stalls, flags underflow.
module regfile_writeback_unit
  import regfile_writeback_unit_pkg::*;
#(
  parameter int ADDR_WIDTH   = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = RF_DATA_WIDTH,
  parameter int CNT_WIDTH    = WB_CNT_WIDTH,
  parameter int STARVE_LIMIT = WB_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  idle,
  output logic                  err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]         starve_cnt;
  logic                  alu_force;
  logic                  alu_take;
  logic                  lsu_take;
  logic                  issue_sat;
  logic                  issue_take;
  logic                  all_zero;
  wb_src_e               src;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  assign alu_force = (starve_cnt >= SW'(STARVE_LIMIT));

  // LSU wins by default; a starved ALU takes the next contested cycle.
  assign lsu_ready = rstn && !(alu_force && alu_valid);
  assign alu_ready = rstn && (!lsu_valid || alu_force);

  assign lsu_take = lsu_valid && lsu_ready;
  assign alu_take = alu_valid && alu_ready;

  always_comb begin
    src      = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    unique case (1'b1)
      lsu_take: begin
        src      = SRC_LSU;
        sel_rd   = lsu_rd;
        sel_data = lsu_data;
      end
      alu_take: begin
        src      = SRC_ALU;
        sel_rd   = alu_rd;
        sel_data = alu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (!alu_valid || alu_ready) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen   <= src_writes(src, sel_rd != '0);
      rf_waddr <= sel_rd;
      rf_wdata <= sel_data;
    end
  end

  assign issue_ready = rstn && ((issue_rd == '0) || !issue_sat);
  assign issue_take  = issue_valid && issue_ready
                    && (issue_rd != '0);

  // Retire happens when the register file latches the value,
  // so busy drops the cycle the new value is readable.
  wb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .inc_en   (issue_take),
    .inc_addr (issue_rd),
    .dec_en   (rf_wen),
    .dec_addr (rf_waddr),
    .q_addr   (issue_rd),
    .q_sat    (issue_sat),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .all_zero (all_zero),
    .err      (err)
  );

  assign idle = all_zero && !rf_wen;

endmodule
